// File: rtl/cache_mem_arbiter.sv
// Shares the single pipelined main memory between the I-cache and D-cache:
// fixed-priority grant, one-cycle write-through stores, and 8-word block fills.
module cache_mem_arbiter #(
    parameter int WORDS  = 8,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_miss,
    input  logic [ADDR_W-1:0] i_miss_addr,
    input  logic              d_miss,
    input  logic [ADDR_W-1:0] d_miss_addr,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_wr_addr,
    input  logic [DATA_W-1:0] d_wr_data,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic              mem_data_valid,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic [DATA_W-1:0] fill_data,
    output logic [2:0]        fill_word,
    output logic              i_fill_we,
    output logic              d_fill_we,
    output logic              i_fill_done,
    output logic              d_fill_done,
    output logic              d_wr_done,
    output logic              busy
);

    localparam int WIDX_W = $clog2(WORDS);
    localparam int CNT_W  = WIDX_W + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_FILL  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_I    = 2'd1;
    localparam logic [1:0] OWN_D    = 2'd2;

    localparam logic [CNT_W-1:0]  ISSUE_END = CNT_W'(WORDS);
    localparam logic [WIDX_W-1:0] RECV_LAST = WIDX_W'(WORDS - 1);
    localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'(2 * WORDS - 1);

    logic [1:0]        r_state;
    logic [1:0]        r_owner;
    logic [ADDR_W-1:0] r_base;
    logic [CNT_W-1:0]  r_issue_cnt;
    logic [WIDX_W-1:0] r_recv_cnt;

    logic w_issue;
    logic w_recv;

    assign w_issue = (r_state == S_FILL) && (r_issue_cnt < ISSUE_END);
    assign w_recv  = (r_state == S_FILL) && mem_data_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_owner     <= OWN_NONE;
            r_base      <= '0;
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (d_wr) begin
                        r_state <= S_WRITE;
                        r_owner <= OWN_D;
                    end else if (d_miss) begin
                        r_state <= S_FILL;
                        r_owner <= OWN_D;
                        r_base  <= d_miss_addr & BASE_MASK;
                    end else if (i_miss) begin
                        r_state <= S_FILL;
                        r_owner <= OWN_I;
                        r_base  <= i_miss_addr & BASE_MASK;
                    end
                end
                S_WRITE: begin
                    r_state <= S_IDLE;
                    r_owner <= OWN_NONE;
                end
                S_FILL: begin
                    if (w_issue) begin
                        r_issue_cnt <= r_issue_cnt + 1'b1;
                    end
                    // The last word leaves recv_cnt at 7; only DONE clears it.
                    if (mem_data_valid) begin
                        if (r_recv_cnt == RECV_LAST) begin
                            r_state <= S_DONE;
                        end else begin
                            r_recv_cnt <= r_recv_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_owner     <= OWN_NONE;
                    r_issue_cnt <= '0;
                    r_recv_cnt  <= '0;
                end
            endcase
        end
    end

    always_comb begin
        mem_en      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_data_in = '0;
        if (r_state == S_WRITE) begin
            mem_en      = 1'b1;
            mem_wr      = 1'b1;
            mem_addr    = d_wr_addr;
            mem_data_in = d_wr_data;
        end else if (w_issue) begin
            mem_en   = 1'b1;
            mem_addr = r_base + ADDR_W'({r_issue_cnt, 1'b0});
        end
    end

    assign fill_data   = w_recv ? mem_data_out : '0;
    assign fill_word   = w_recv ? r_recv_cnt : '0;
    assign i_fill_we   = w_recv && (r_owner == OWN_I);
    assign d_fill_we   = w_recv && (r_owner == OWN_D);
    assign i_fill_done = (r_state == S_DONE) && (r_owner == OWN_I);
    assign d_fill_done = (r_state == S_DONE) && (r_owner == OWN_D);
    assign d_wr_done   = (r_state == S_WRITE);
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter: stimulus pushes cycle-stamped
// expectations, a negedge monitor pops and compares whatever the DUT presents.
module tb_cache_mem_arbiter;

    localparam int WORDS  = 8;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    logic              clk;
    logic              rst;
    logic              i_miss;
    logic [ADDR_W-1:0] i_miss_addr;
    logic              d_miss;
    logic [ADDR_W-1:0] d_miss_addr;
    logic              d_wr;
    logic [ADDR_W-1:0] d_wr_addr;
    logic [DATA_W-1:0] d_wr_data;
    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_in;
    logic              mem_data_valid;
    logic [DATA_W-1:0] mem_data_out;
    logic [DATA_W-1:0] fill_data;
    logic [2:0]        fill_word;
    logic              i_fill_we;
    logic              d_fill_we;
    logic              i_fill_done;
    logic              d_fill_done;
    logic              d_wr_done;
    logic              busy;

    cache_mem_arbiter #(
        .WORDS (WORDS),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_miss        (i_miss),
        .i_miss_addr   (i_miss_addr),
        .d_miss        (d_miss),
        .d_miss_addr   (d_miss_addr),
        .d_wr          (d_wr),
        .d_wr_addr     (d_wr_addr),
        .d_wr_data     (d_wr_data),
        .mem_en        (mem_en),
        .mem_wr        (mem_wr),
        .mem_addr      (mem_addr),
        .mem_data_in   (mem_data_in),
        .mem_data_valid(mem_data_valid),
        .mem_data_out  (mem_data_out),
        .fill_data     (fill_data),
        .fill_word     (fill_word),
        .i_fill_we     (i_fill_we),
        .d_fill_we     (d_fill_we),
        .i_fill_done   (i_fill_done),
        .d_fill_done   (d_fill_done),
        .d_wr_done     (d_wr_done),
        .busy          (busy)
    );

    typedef struct {
        int          cyc;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] data;
    } mem_exp_t;

    typedef struct {
        int          cyc;
        logic        tgt_d;
        logic [2:0]  word;
        logic [15:0] data;
    } fill_exp_t;

    typedef struct {
        int         cyc;
        logic [2:0] ev;   // {i_fill_done, d_fill_done, d_wr_done}
    } ev_exp_t;

    mem_exp_t  q_mem[$];
    fill_exp_t q_fill[$];
    ev_exp_t   q_ev[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [58:0] w_outs;
    assign w_outs = {mem_en, mem_wr, mem_addr, mem_data_in, fill_data, fill_word,
                     i_fill_we, d_fill_we, i_fill_done, d_fill_done, d_wr_done, busy};

    function automatic logic [15:0] memfun(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h3C96;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: 4-cycle read latency, reads sampled mid-cycle, returns
    // presented just after the edge. Not reset, so in-flight words survive rst.
    logic [3:0]  pv;
    logic [15:0] pa[4];
    logic        inj_valid;
    logic [15:0] inj_data;
    logic        smp_rd;
    logic [15:0] smp_addr;

    assign mem_data_valid = pv[3] | inj_valid;
    assign mem_data_out   = inj_valid ? inj_data : memfun(pa[3]);

    initial begin
        pv = '0;
        for (int i = 0; i < 4; i++) pa[i] = '0;
        forever begin
            @(negedge clk);
            smp_rd   = mem_en && !mem_wr && !rst;
            smp_addr = mem_addr;
            @(posedge clk);
            #1;
            pa[3] = pa[2];
            pa[2] = pa[1];
            pa[1] = pa[0];
            pa[0] = smp_addr;
            pv    = {pv[2:0], smp_rd};
        end
    end

    // Monitor
    initial begin
        mem_exp_t  me;
        fill_exp_t fe;
        ev_exp_t   ee;
        logic [2:0] ev;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (mem_en) begin
                    total++;
                    if (q_mem.size() == 0) begin
                        bad++;
                        $display("FAIL mem_unexpected cyc=%0d got wr=%b addr=%h data=%h",
                                 cyc, mem_wr, mem_addr, mem_data_in);
                    end else begin
                        me = q_mem.pop_front();
                        if (me.cyc != cyc || me.wr !== mem_wr || me.addr !== mem_addr ||
                            me.data !== mem_data_in) begin
                            bad++;
                            $display("FAIL mem_req got cyc=%0d wr=%b addr=%h data=%h want cyc=%0d wr=%b addr=%h data=%h",
                                     cyc, mem_wr, mem_addr, mem_data_in, me.cyc, me.wr, me.addr, me.data);
                        end
                    end
                end else begin
                    total++;
                    if ({mem_wr, mem_addr, mem_data_in} !== '0) begin
                        bad++;
                        $display("FAIL mem_quiet cyc=%0d got wr=%b addr=%h data=%h want all 0",
                                 cyc, mem_wr, mem_addr, mem_data_in);
                    end
                end

                if (i_fill_we || d_fill_we) begin
                    total++;
                    if (q_fill.size() == 0) begin
                        bad++;
                        $display("FAIL fill_unexpected cyc=%0d got iwe=%b dwe=%b word=%0d data=%h",
                                 cyc, i_fill_we, d_fill_we, fill_word, fill_data);
                    end else begin
                        fe = q_fill.pop_front();
                        if (fe.cyc != cyc || d_fill_we !== fe.tgt_d || i_fill_we !== !fe.tgt_d ||
                            fe.word !== fill_word || fe.data !== fill_data) begin
                            bad++;
                            $display("FAIL fill_word got cyc=%0d iwe=%b dwe=%b word=%0d data=%h want cyc=%0d iwe=%b dwe=%b word=%0d data=%h",
                                     cyc, i_fill_we, d_fill_we, fill_word, fill_data,
                                     fe.cyc, !fe.tgt_d, fe.tgt_d, fe.word, fe.data);
                        end
                    end
                end else begin
                    total++;
                    if ({fill_data, fill_word} !== '0) begin
                        bad++;
                        $display("FAIL fill_quiet cyc=%0d got word=%0d data=%h want 0",
                                 cyc, fill_word, fill_data);
                    end
                end

                ev = {i_fill_done, d_fill_done, d_wr_done};
                if (ev != 3'b000) begin
                    total++;
                    if (q_ev.size() == 0) begin
                        bad++;
                        $display("FAIL done_unexpected cyc=%0d got ev=%b", cyc, ev);
                    end else begin
                        ee = q_ev.pop_front();
                        if (ee.cyc != cyc || ee.ev !== ev) begin
                            bad++;
                            $display("FAIL done_pulse got cyc=%0d ev=%b want cyc=%0d ev=%b",
                                     cyc, ev, ee.cyc, ee.ev);
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int c);
        while (cyc < c) tick();
    endtask

    // Fill granted at the end of cycle c0: reads issue from c0+1, words
    // return from c0+5, done pulses at c0+13.
    task automatic push_fill(input int c0, input logic tgt_d, input logic [15:0] addr,
                             input int n_issue, input int n_recv, input logic with_done);
        logic [15:0] base;
        logic [15:0] a;
        mem_exp_t    me;
        fill_exp_t   fe;
        ev_exp_t     ee;
        base = {addr[15:4], 4'h0};
        for (int k = 0; k < WORDS; k++) begin
            a = base + 16'(2 * k);
            if (k < n_issue) begin
                me.cyc = c0 + 1 + k; me.wr = 1'b0; me.addr = a; me.data = 16'h0;
                q_mem.push_back(me);
            end
            if (k < n_recv) begin
                fe.cyc = c0 + 5 + k; fe.tgt_d = tgt_d; fe.word = 3'(k); fe.data = memfun(a);
                q_fill.push_back(fe);
            end
        end
        if (with_done) begin
            ee.cyc = c0 + 13;
            ee.ev  = tgt_d ? 3'b010 : 3'b100;
            q_ev.push_back(ee);
        end
    endtask

    initial begin
        int       c0;
        int       c1;
        mem_exp_t me;
        ev_exp_t  ee;

        rst = 1'b1;
        i_miss = 1'b0; i_miss_addr = '0;
        d_miss = 1'b0; d_miss_addr = '0;
        d_wr = 1'b0; d_wr_addr = '0; d_wr_data = '0;
        inj_valid = 1'b0; inj_data = '0;

        repeat (3) tick();
        chk("reset_outputs", 64'(w_outs), 64'h0);
        rst = 1'b0;
        tick();
        chk("idle_outputs", 64'(w_outs), 64'h0);

        // Single I fill from a mid-block address
        tick();
        c0 = cyc;
        i_miss = 1'b1; i_miss_addr = 16'h1236;
        push_fill(c0, 1'b0, 16'h1236, 8, 8, 1'b1);
        tick();
        chk("busy_in_fill", 64'(busy), 64'h1);
        goto(c0 + 14);
        i_miss = 1'b0;
        chk("busy_after_i_fill", 64'(busy), 64'h0);

        // Simultaneous D and I miss: D wins, one IDLE cycle, then I
        tick();
        c0 = cyc;
        d_miss = 1'b1; d_miss_addr = 16'h0040;
        i_miss = 1'b1; i_miss_addr = 16'h2000;
        push_fill(c0, 1'b1, 16'h0040, 8, 8, 1'b1);
        push_fill(c0 + 14, 1'b0, 16'h2000, 8, 8, 1'b1);
        goto(c0 + 14);
        d_miss = 1'b0;
        chk("idle_between_grants", 64'(busy), 64'h0);
        goto(c0 + 28);
        i_miss = 1'b0;

        // Write-through with a concurrent D miss: store first
        tick();
        c0 = cyc;
        d_wr = 1'b1; d_wr_addr = 16'h0102; d_wr_data = 16'hBEEF;
        d_miss = 1'b1; d_miss_addr = 16'h0300;
        me.cyc = c0 + 1; me.wr = 1'b1; me.addr = 16'h0102; me.data = 16'hBEEF;
        q_mem.push_back(me);
        ee.cyc = c0 + 1; ee.ev = 3'b001;
        q_ev.push_back(ee);
        push_fill(c0 + 2, 1'b1, 16'h0300, 8, 8, 1'b1);
        goto(c0 + 2);
        d_wr = 1'b0;
        chk("idle_after_write", 64'(busy), 64'h0);
        goto(c0 + 16);
        d_miss = 1'b0;

        // I request dropped mid-fill: fill still completes
        tick();
        c0 = cyc;
        i_miss = 1'b1; i_miss_addr = 16'h4458;
        push_fill(c0, 1'b0, 16'h4458, 8, 8, 1'b1);
        goto(c0 + 3);
        i_miss = 1'b0;
        goto(c0 + 14);

        // Stray valid while idle
        tick();
        inj_data = 16'h7777; inj_valid = 1'b1;
        #1;
        chk("stray_valid_no_we", 64'({i_fill_we, d_fill_we, fill_data, fill_word}), 64'h0);
        tick();
        inj_valid = 1'b0;
        tick();

        // Reset after three words received
        c0 = cyc;
        i_miss = 1'b1; i_miss_addr = 16'h5500;
        push_fill(c0, 1'b0, 16'h5500, 7, 3, 1'b0);
        goto(c0 + 8);
        #1;
        rst = 1'b1;
        i_miss = 1'b0;
        #1;
        chk("outputs_in_midfill_reset", 64'(w_outs), 64'h0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        goto(c0 + 13);
        c1 = cyc;
        d_miss = 1'b1; d_miss_addr = 16'h0A3C;
        push_fill(c1, 1'b1, 16'h0A3C, 8, 8, 1'b1);
        goto(c1 + 14);
        d_miss = 1'b0;

        // Address at top of the space: no carry past 16 bits
        tick();
        c0 = cyc;
        i_miss = 1'b1; i_miss_addr = 16'hFFF4;
        push_fill(c0, 1'b0, 16'hFFF4, 8, 8, 1'b1);
        goto(c0 + 14);
        i_miss = 1'b0;

        repeat (6) tick();
        chk("mem_queue_drained", 64'(q_mem.size()), 64'h0);
        chk("fill_queue_drained", 64'(q_fill.size()), 64'h0);
        chk("done_queue_drained", 64'(q_ev.size()), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
